// File: rtl/rf_arb_pkg.sv
// Shared register-file write types for rf_write_arbiter and its round-robin arbiter.
// The optional forwarding stage in the top level is enabled with RF_WR_FWD_EN.
package rf_arb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t ZERO_REG = 5'd0;

  typedef struct packed {
    reg_addr_t   addr;
    logic [31:0] data;
  } wr_req_t;

  // Register 0 is hard-wired, so writes to it are discarded and reads never forward.
  function automatic logic is_live_reg(input reg_addr_t addr);
    return addr != ZERO_REG;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past last_ptr and wraps,
// the first asserted request wins.
module rr_arbiter
  import rf_arb_pkg::*;
#(
  parameter  int NUM_REQ = 3,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx
);

  int               pos;
  logic [IDX_W-1:0] sel;
  logic             found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    pos     = 0;
    sel     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      pos = (int'(last_ptr) + k) % NUM_REQ;
      sel = IDX_W'(pos);
      if (!found && req[sel]) begin
        found    = 1'b1;
        gnt[sel] = 1'b1;
        gnt_idx  = sel;
      end
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register_file write port among NUM_REQ requesters.
// Define RF_WR_FWD_EN to add the read-data forwarding ports and compare logic.
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter  int NUM_REQ = 3,
  parameter  int DATA_W  = 32,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_hold,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*REG_ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data,
  output reg_addr_t                    rd_addr,
  output logic [DATA_W-1:0]            rd_w_data,
  output logic [IDX_W-1:0]             grant_id
`ifdef RF_WR_FWD_EN
  ,
  input  reg_addr_t                    rs_addr,
  input  reg_addr_t                    rt_addr,
  input  logic [DATA_W-1:0]            rs_data_rf,
  input  logic [DATA_W-1:0]            rt_data_rf,
  output logic [DATA_W-1:0]            rs_data,
  output logic [DATA_W-1:0]            rt_data
`endif
);

  logic [IDX_W-1:0]   last_ptr_q, last_ptr_d;
  reg_addr_t          rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0]  rd_w_data_q, rd_w_data_d;
  logic [IDX_W-1:0]   grant_id_q, grant_id_d;

  logic [NUM_REQ-1:0] req_elig;
  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               xfer;
  reg_addr_t          sel_addr;
  logic [DATA_W-1:0]  sel_data;

  // Requests are masked rather than grants so the pointer never moves while held or in reset.
  assign req_elig = (rst && !wr_hold) ? req_valid : '0;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req      (req_elig),
    .last_ptr (last_ptr_q),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx)
  );

  assign req_ready = gnt;
  assign xfer      = |gnt;

  // One-hot AND-OR mux keeps the selection free of variable part-selects.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_addr = sel_addr | req_addr[i*REG_ADDR_W +: REG_ADDR_W];
        sel_data = sel_data | req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    last_ptr_d  = last_ptr_q;
    grant_id_d  = grant_id_q;
    rd_addr_d   = ZERO_REG;
    rd_w_data_d = '0;
    if (xfer) begin
      last_ptr_d  = gnt_idx;
      grant_id_d  = gnt_idx;
      rd_addr_d   = sel_addr;
      rd_w_data_d = sel_data;
    end
  end

  // Reset pointer at the last index so requester 0 wins first after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_ptr_q  <= IDX_W'(NUM_REQ - 1);
      grant_id_q  <= '0;
      rd_addr_q   <= ZERO_REG;
      rd_w_data_q <= '0;
    end else begin
      last_ptr_q  <= last_ptr_d;
      grant_id_q  <= grant_id_d;
      rd_addr_q   <= rd_addr_d;
      rd_w_data_q <= rd_w_data_d;
    end
  end

  assign rd_addr   = rd_addr_q;
  assign rd_w_data = rd_w_data_q;
  assign grant_id  = grant_id_q;

`ifdef RF_WR_FWD_EN
  function automatic logic [DATA_W-1:0] fwd_sel(
    input reg_addr_t         rd_a,
    input reg_addr_t         wr_a,
    input logic [DATA_W-1:0] wr_d,
    input logic [DATA_W-1:0] raw
  );
    return (is_live_reg(rd_a) && rd_a == wr_a) ? wr_d : raw;
  endfunction

  assign rs_data = fwd_sel(rs_addr, rd_addr_q, rd_w_data_q, rs_data_rf);
  assign rt_data = fwd_sel(rt_addr, rd_addr_q, rd_w_data_q, rt_data_rf);
`endif

endmodule
